// File: rtl/ram_burst_serializer_pkg.sv
// -----------------------------------------------------------------------------
// ram_burst_serializer_pkg
//
// Shared definitions for the RAM burst serializer:
//   - state encodings for the controller FSM (IDLE/LOAD/SHIFT/DONE)
//   - state_t enum built on those encodings
//   - clog2_min1() helper used to size the per-word bit counter
// No ports; imported with `import ram_burst_serializer_pkg::*;`.
// -----------------------------------------------------------------------------
package ram_burst_serializer_pkg;

  // Fixed state encodings; the enum below is tied to them so that the
  // encoding seen on a debug probe never depends on tool choices.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  // Ceiling log2 with a floor of 1 bit, so a 1-bit word still gets a
  // legal (1-bit) counter.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) begin
        r = i + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ram_burst_serializer_if.sv
// -----------------------------------------------------------------------------
// ram_burst_serializer_if
//
// Bundles every non-clock signal of the serializer:
//   start/base_addr/count  run request (from the controller above)
//   addr_rd/rd_data        RAM asynchronous read port
//   ser_valid/ser_data/ser_ready/ser_last  1-bit serial stream
//   busy/done              status
// Modports:
//   master - the serializer itself
//   slave  - its environment (requester, RAM read port, serial consumer)
// -----------------------------------------------------------------------------
interface ram_burst_serializer_if #(
  parameter int addr_width = 2,
  parameter int data_width = 3
) ();

  logic                  start;
  logic [addr_width-1:0] base_addr;
  logic [addr_width:0]   count;
  logic [addr_width-1:0] addr_rd;
  logic [data_width-1:0] rd_data;
  logic                  ser_valid;
  logic                  ser_data;
  logic                  ser_ready;
  logic                  ser_last;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, base_addr, count, rd_data, ser_ready,
    output addr_rd, ser_valid, ser_data, ser_last, busy, done
  );

  modport slave (
    output start, base_addr, count, rd_data, ser_ready,
    input  addr_rd, ser_valid, ser_data, ser_last, busy, done
  );

endinterface

// File: rtl/ram_burst_serializer_piso_shreg.sv
// -----------------------------------------------------------------------------
// piso_shreg
//
// Parallel-in / serial-out shift register for one RAM word, LSB first.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_en      capture din and clear the bit counter
//   shift_en     shift right by one (zero fill) and count the bit
//   din          parallel word
//   dout         current serial bit (shreg[0])
//   last_bit     high while the bit on dout is the word's final bit
// load_en has priority over shift_en.
// -----------------------------------------------------------------------------
module piso_shreg
  import ram_burst_serializer_pkg::*;
#(
  parameter int data_width = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic                  shift_en,
  input  logic [data_width-1:0] din,
  output logic                  dout,
  output logic                  last_bit
);

  localparam int cnt_w = clog2_min1(data_width);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(data_width - 1);

  logic [data_width-1:0] shreg_reg;
  logic [data_width-1:0] shreg_next;
  logic [cnt_w-1:0]      bit_cnt_reg;

  // Right-shift network: each bit takes its upper neighbour, the MSB
  // takes zero. Written bit-wise so data_width = 1 needs no special slice.
  for (genvar gi = 0; gi < data_width; gi++) begin : g_shift
    if (gi == data_width - 1) begin : g_msb
      assign shreg_next[gi] = 1'b0;
    end else begin : g_lower
      assign shreg_next[gi] = shreg_reg[gi+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (load_en) begin
      shreg_reg   <= din;
      bit_cnt_reg <= '0;
    end else if (shift_en) begin
      shreg_reg   <= shreg_next;
      // May step past cnt_last after the final bit; the next load clears it.
      bit_cnt_reg <= bit_cnt_reg + cnt_w'(1);
    end
  end

  assign dout     = shreg_reg[0];
  assign last_bit = (bit_cnt_reg == cnt_last);

endmodule

// File: rtl/ram_burst_serializer.sv
// -----------------------------------------------------------------------------
// ram_burst_serializer
//
// Reads a run of consecutive RAM words through the RAM's asynchronous read
// port and streams each word LSB-first over a 1-bit valid/ready channel.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts a run, no done)
//   bus    ram_burst_serializer_if.master:
//            start/base_addr/count  run request, sampled only in IDLE
//            addr_rd -> RAM, rd_data <- RAM dout (combinational)
//            ser_valid/ser_data/ser_ready/ser_last serial stream
//            busy (LOAD/SHIFT), done (one-cycle completion pulse)
// Per word: one LOAD cycle capturing rd_data, then data_width SHIFT
// handshakes. Address increments modulo 2**addr_width between words.
// -----------------------------------------------------------------------------
module ram_burst_serializer
  import ram_burst_serializer_pkg::*;
#(
  parameter int addr_width = 2,
  parameter int data_width = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ram_burst_serializer_if.master  bus
);

  localparam logic [addr_width:0] rem_one = (addr_width + 1)'(1);

  state_t                state_reg;
  logic [addr_width-1:0] addr_reg;
  logic [addr_width:0]   remaining_reg;
  logic                  valid_reg;
  logic                  busy_reg;
  logic                  done_reg;

  logic load_en;
  logic shift_en;
  logic bit_last;
  logic shreg_lsb;

  // The RAM word is captured in the single LOAD cycle; anything written to
  // that address afterwards does not reach the word already in flight.
  assign load_en  = (state_reg == LOAD);
  assign shift_en = valid_reg && bus.ser_ready;

  piso_shreg #(
    .data_width (data_width)
  ) u_piso_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (load_en),
    .shift_en (shift_en),
    .din      (bus.rd_data),
    .dout     (shreg_lsb),
    .last_bit (bit_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            if (bus.count != '0) begin
              addr_reg      <= bus.base_addr;
              remaining_reg <= bus.count;
              busy_reg      <= 1'b1;
              state_reg     <= LOAD;
            end else begin
              // Empty run: report completion without touching the stream.
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end
          end
        end

        LOAD: begin
          valid_reg <= 1'b1;
          state_reg <= SHIFT;
        end

        SHIFT: begin
          if (bus.ser_ready && bit_last) begin
            valid_reg <= 1'b0;
            if (remaining_reg == rem_one) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              remaining_reg <= remaining_reg - rem_one;
              addr_reg      <= addr_reg + addr_width'(1);
              state_reg     <= LOAD;
            end
          end
        end

        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.addr_rd   = addr_reg;
  assign bus.ser_valid = valid_reg;
  assign bus.ser_data  = shreg_lsb;
  // Decoded purely from registers, so it is glitch-free and holds under
  // backpressure together with ser_data.
  assign bus.ser_last  = (state_reg == SHIFT) && (remaining_reg == rem_one) && bit_last;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_ram_burst_serializer.sv
// -----------------------------------------------------------------------------
// tb_ram_burst_serializer
//
// Directed runs against a 4x3 RAM model; expected bit streams are pushed
// into a queue when a run is issued and a negedge monitor pops/compares on
// every serial handshake.
// -----------------------------------------------------------------------------
module tb_ram_burst_serializer;

  localparam int aw = 2;
  localparam int dw = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ram_burst_serializer_if #(.addr_width(aw), .data_width(dw)) bus ();

  ram_burst_serializer #(.addr_width(aw), .data_width(dw)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // RAM model with asynchronous read.
  logic [dw-1:0] mem [0:3];
  assign bus.rd_data = mem[bus.addr_rd];

  typedef struct {
    logic          d;
    logic          last;
    logic [aw-1:0] addr;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  bit first_pending = 0;
  bit busy_seen = 0;
  bit valid_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cycle counter: value k during the k-th clock period.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit            stall_pending;
    logic          hold_d;
    logic          hold_last;
    logic [aw-1:0] hold_addr;
    exp_t          e;
    stall_pending = 0;
    hold_d = 0;
    hold_last = 0;
    hold_addr = '0;
    forever begin
      @(negedge clk);
      if (bus.busy) busy_seen = 1;
      if (bus.ser_valid) valid_seen = 1;
      if (stall_pending && bus.ser_valid) begin
        chk("hold_data", 32'(bus.ser_data), 32'(hold_d));
        chk("hold_last", 32'(bus.ser_last), 32'(hold_last));
        chk("hold_addr", 32'(bus.addr_rd), 32'(hold_addr));
      end
      stall_pending = bus.ser_valid && !bus.ser_ready;
      hold_d    = bus.ser_data;
      hold_last = bus.ser_last;
      hold_addr = bus.addr_rd;
      if (bus.ser_valid && bus.ser_ready) begin
        $display("cycle %0d: bit data=%0d last=%0d addr=%0d",
                 cyc - start_cyc, bus.ser_data, bus.ser_last, bus.addr_rd);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bit: got data %0d, expected no bit", bus.ser_data);
        end else begin
          e = exp_q.pop_front();
          chk("ser_data", 32'(bus.ser_data), 32'(e.d));
          chk("ser_last", 32'(bus.ser_last), 32'(e.last));
          chk("addr_rd", 32'(bus.addr_rd), 32'(e.addr));
        end
        if (first_pending) begin
          chk("first_bit_cycle", 32'(cyc - start_cyc), 32'd2);
          first_pending = 0;
        end
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        $display("cycle %0d: done", cyc - start_cyc);
      end
    end
  end

  task automatic push_exp(input int cnt, input logic [11:0] bits,
                          input logic [3:0][aw-1:0] addrs);
    int nbits;
    nbits = cnt * dw;
    for (int i = 0; i < nbits; i++) begin
      exp_t e;
      e.d    = bits[i];
      e.last = (i == nbits - 1);
      e.addr = addrs[i / dw];
      exp_q.push_back(e);
    end
  endtask

  // Issue one run (called just after a posedge) and wait for its done.
  task automatic run(input string name, input logic [aw-1:0] base, input logic [aw:0] cnt,
                     input logic [11:0] bits, input logic [3:0][aw-1:0] addrs,
                     input int stall_at, input int stall_len, input int restart_at,
                     input int exp_done);
    int dc0;
    push_exp(int'(cnt), bits, addrs);
    dc0 = done_cnt;
    busy_seen = 0;
    valid_seen = 0;
    first_pending = (cnt != 0);
    bus.start = 1'b1;
    bus.base_addr = base;
    bus.count = cnt;
    bus.ser_ready = 1'b1;
    start_cyc = cyc;
    for (int t = 1; t < 200 && done_cnt == dc0; t++) begin
      @(posedge clk);
      #1;
      bus.start = (t == restart_at);
      if (t == restart_at) begin
        bus.base_addr = '0;
        bus.count = 3'd1;
      end
      bus.ser_ready = !(stall_at >= 0 && t >= stall_at && t < stall_at + stall_len);
    end
    if (done_cnt == dc0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done, expected done within 200 cycles", name);
    end else begin
      chk({name, "_done_cycle"}, 32'(done_cyc - start_cyc), 32'(exp_done));
    end
    bus.ser_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk({name, "_done_pulses"}, 32'(done_cnt - dc0), 32'd1);
    chk({name, "_bits_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_addr_rd"}, 32'(bus.addr_rd), 32'd0);
    chk({name, "_ser_valid"}, 32'(bus.ser_valid), 32'd0);
    chk({name, "_ser_data"}, 32'(bus.ser_data), 32'd0);
    chk({name, "_ser_last"}, 32'(bus.ser_last), 32'd0);
    chk({name, "_busy"}, 32'(bus.busy), 32'd0);
    chk({name, "_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc0;
    mem[0] = 3'b101;
    mem[1] = 3'b011;
    mem[2] = 3'b110;
    mem[3] = 3'b001;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.count = '0;
    bus.ser_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Words 1 (011) and 2 (110), LSB first: 1,1,0,0,1,1.
    run("basic", 2'd1, 3'd2, 12'b000000_110011, {2'd0, 2'd0, 2'd2, 2'd1}, -1, 0, -1, 9);
    // Words 3 (001) and 0 (101): 1,0,0,1,0,1.
    run("wrap", 2'd3, 3'd2, 12'b000000_101001, {2'd0, 2'd0, 2'd0, 2'd3}, -1, 0, -1, 9);
    // Second bit of the first word stalled for 3 cycles.
    run("stall", 2'd1, 3'd2, 12'b000000_110011, {2'd0, 2'd0, 2'd2, 2'd1}, 3, 3, -1, 12);
    // Empty run.
    run("zero", 2'd0, 3'd0, 12'b0, {2'd0, 2'd0, 2'd0, 2'd0}, -1, 0, -1, 1);
    chk("zero_busy_seen", 32'(busy_seen), 32'd0);
    chk("zero_valid_seen", 32'(valid_seen), 32'd0);
    // Full memory from 2: 0,1,1, 1,0,0, 1,0,1, 1,1,0.
    run("full", 2'd2, 3'd4, 12'b0111_0100_1110, {2'd1, 2'd0, 2'd3, 2'd2}, -1, 0, -1, 17);
    // Start pulse during SHIFT must be ignored.
    run("restart", 2'd1, 3'd2, 12'b000000_110011, {2'd0, 2'd0, 2'd2, 2'd1}, -1, 0, 3, 9);

    // Asynchronous reset in the middle of SHIFT.
    push_exp(2, 12'b000000_110011, {2'd0, 2'd0, 2'd2, 2'd1});
    dc0 = done_cnt;
    first_pending = 1;
    bus.start = 1'b1;
    bus.base_addr = 2'd1;
    bus.count = 3'd2;
    start_cyc = cyc;
    for (int t = 1; t <= 3; t++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrun_reset");
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrun_reset_no_done", 32'(done_cnt - dc0), 32'd0);
    run("after_reset", 2'd0, 3'd1, 12'b000000_000101, {2'd0, 2'd0, 2'd0, 2'd0}, -1, 0, -1, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
